// File: rtl/tucanos_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tucanos_dispatcher
// Description : OS-side preemption dispatcher with a 3-entry process table.
//               Optional counters enabled by the macro DISPATCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tucanos_dispatcher #(
    parameter logic [11:0] OS_ENTRY_ADDR = 12'd256,
    parameter logic [11:0] PROC1_BASE    = 12'd512,
    parameter logic [11:0] PROC2_BASE    = 12'd1024,
    parameter logic [11:0] PROC3_BASE    = 12'd1536,
    parameter logic [5:0]  SYSRET_OP     = 6'b100100
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        jump_enabler,
    input  logic [31:0] state_register,
    input  logic [11:0] program_counter,
    input  logic [5:0]  opcode,
    input  logic [2:0]  io_done,
    output logic        pc_override_valid,
    output logic [11:0] pc_override,
    output logic        mux_system_instruction,
    output logic [1:0]  current_process,
    output logic [2:0]  cause,
`ifdef DISPATCH_STATS_EN
    output logic        all_halted,
    output logic [15:0] switch_count,
    output logic [15:0] io_wait_cycles
`else
    output logic        all_halted
`endif
);

    typedef enum logic [2:0] {
        ST_USER    = 3'd0,
        ST_ENTER   = 3'd1,
        ST_OS      = 3'd2,
        ST_SELECT  = 3'd3,
        ST_RESTORE = 3'd4,
        ST_STOP    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PS_READY   = 2'd0,
        PS_WAITING = 2'd1,
        PS_HALTED  = 2'd2
    } pstat_e;

    state_e      state_q, state_d;
    logic [1:0]  cur_q, cur_d;
    logic [1:0]  hint_q, hint_d;
    logic [2:0]  cause_q, cause_d;
    logic        valid_q, valid_d;
    logic [11:0] pc_ov_q, pc_ov_d;
    logic        mux_q, mux_d;
    logic        halted_q, halted_d;
    logic [11:0] saved_pc_q [1:3];
    logic [11:0] saved_pc_d [1:3];
    pstat_e      status_q [1:3];
    pstat_e      status_d [1:3];

    logic [3:0]  ready_vec;
    logic        any_wait;
    logic [1:0]  pick;
    logic        code_valid;

    function automatic logic [1:0] rr_next(input logic [1:0] cur, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (sum > 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    assign code_valid = (state_register != 32'd0) && (state_register <= 32'd5);

    // Descending loop so the closest round-robin candidate is assigned last and wins.
    always_comb begin
        ready_vec = 4'b0000;
        any_wait  = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            ready_vec[i] = (status_q[i] == PS_READY);
            if (status_q[i] == PS_WAITING) begin
                any_wait = 1'b1;
            end
        end
        pick = 2'd0;
        if ((cause_q == 3'd1) && ready_vec[hint_q]) begin
            pick = hint_q;
        end else begin
            for (int k = 3; k >= 1; k--) begin
                if (ready_vec[rr_next(cur_q, 2'(k))]) begin
                    pick = rr_next(cur_q, 2'(k));
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        hint_d   = hint_q;
        cause_d  = cause_q;
        valid_d  = 1'b0;
        pc_ov_d  = pc_ov_q;
        mux_d    = mux_q;
        halted_d = halted_q;
        for (int i = 1; i <= 3; i++) begin
            saved_pc_d[i] = saved_pc_q[i];
            status_d[i]   = (status_q[i] == PS_WAITING && io_done[i-1]) ? PS_READY : status_q[i];
        end
        case (state_q)
            ST_USER: begin
                if (jump_enabler && code_valid) begin
                    saved_pc_d[cur_q] = program_counter;
                    state_d           = ST_ENTER;
                    valid_d           = 1'b1;
                    pc_ov_d           = OS_ENTRY_ADDR;
                    mux_d             = 1'b0;
                    // A wait code overrides a same-cycle io_done for the running process.
                    if (state_register <= 32'd3) begin
                        cause_d = 3'd1;
                        hint_d  = state_register[1:0];
                    end else if (state_register == 32'd4) begin
                        cause_d         = 3'd4;
                        status_d[cur_q] = PS_WAITING;
                    end else begin
                        cause_d         = 3'd5;
                        status_d[cur_q] = PS_HALTED;
                    end
                end
            end
            ST_ENTER: state_d = ST_OS;
            ST_OS: begin
                if (opcode == SYSRET_OP) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (pick != 2'd0) begin
                    state_d = ST_RESTORE;
                    valid_d = 1'b1;
                    pc_ov_d = saved_pc_q[pick];
                    cur_d   = pick;
                    mux_d   = 1'b1;
                end else if (!any_wait) begin
                    state_d  = ST_STOP;
                    halted_d = 1'b1;
                end
            end
            ST_RESTORE: state_d = ST_USER;
            ST_STOP:    state_d = ST_STOP;
            default:    state_d = ST_USER;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_USER;
            cur_q         <= 2'd1;
            hint_q        <= 2'd1;
            cause_q       <= 3'd0;
            valid_q       <= 1'b0;
            pc_ov_q       <= 12'd0;
            mux_q         <= 1'b1;
            halted_q      <= 1'b0;
            saved_pc_q[1] <= PROC1_BASE;
            saved_pc_q[2] <= PROC2_BASE;
            saved_pc_q[3] <= PROC3_BASE;
            for (int i = 1; i <= 3; i++) begin
                status_q[i] <= PS_READY;
            end
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            hint_q   <= hint_d;
            cause_q  <= cause_d;
            valid_q  <= valid_d;
            pc_ov_q  <= pc_ov_d;
            mux_q    <= mux_d;
            halted_q <= halted_d;
            for (int i = 1; i <= 3; i++) begin
                saved_pc_q[i] <= saved_pc_d[i];
                status_q[i]   <= status_d[i];
            end
        end
    end

    assign pc_override_valid      = valid_q;
    assign pc_override            = pc_ov_q;
    assign mux_system_instruction = mux_q;
    assign current_process        = cur_q;
    assign cause                  = cause_q;
    assign all_halted             = halted_q;

`ifdef DISPATCH_STATS_EN
    logic [15:0] switch_count_q;
    logic [15:0] io_wait_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            switch_count_q <= 16'd0;
            io_wait_q      <= 16'd0;
        end else if (state_q == ST_SELECT) begin
            if (pick != 2'd0) begin
                if (switch_count_q != 16'hFFFF) begin
                    switch_count_q <= switch_count_q + 16'd1;
                end
            end else if (io_wait_q != 16'hFFFF) begin
                io_wait_q <= io_wait_q + 16'd1;
            end
        end
    end

    assign switch_count   = switch_count_q;
    assign io_wait_cycles = io_wait_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tucanos_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_tucanos_dispatcher
// Description : Self-checking bench for tucanos_dispatcher with an event-level
//               process-table model; honours DISPATCH_STATS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tucanos_dispatcher;

    localparam int          HALF   = 5;
    localparam logic [5:0]  SYSRET = 6'b100100;
    localparam int          M_RUN  = 0;
    localparam int          M_OS   = 1;
    localparam int          M_SEL  = 2;
    localparam int          M_STOP = 3;
    localparam int          S_RDY  = 0;
    localparam int          S_WAIT = 1;
    localparam int          S_HALT = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        jump_enabler;
    logic [31:0] state_register;
    logic [11:0] program_counter;
    logic [5:0]  opcode;
    logic [2:0]  io_done;
    wire         pc_override_valid;
    wire  [11:0] pc_override;
    wire         mux_system_instruction;
    wire  [1:0]  current_process;
    wire  [2:0]  cause;
    wire         all_halted;
`ifdef DISPATCH_STATS_EN
    wire  [15:0] switch_count;
    wire  [15:0] io_wait_cycles;
`endif

    always #HALF clock = ~clock;

    tucanos_dispatcher dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .jump_enabler           (jump_enabler),
        .state_register         (state_register),
        .program_counter        (program_counter),
        .opcode                 (opcode),
        .io_done                (io_done),
        .pc_override_valid      (pc_override_valid),
        .pc_override            (pc_override),
        .mux_system_instruction (mux_system_instruction),
        .current_process        (current_process),
        .cause                  (cause),
`ifdef DISPATCH_STATS_EN
        .all_halted             (all_halted),
        .switch_count           (switch_count),
        .io_wait_cycles         (io_wait_cycles)
`else
        .all_halted             (all_halted)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: process table plus a coarse run/OS/select/stop mode; an override
    // pulse marks a transit cycle in which no new request is honoured.
    int   m_mode;
    int   m_status [1:3];
    int   m_saved  [1:3];
    int   m_cur, m_cause, m_hint;
    int   m_sw, m_wt;
    bit   e_valid, e_mux, e_halt;
    int   e_pc;

    task automatic model_reset();
        m_mode = M_RUN;
        for (int i = 1; i <= 3; i++) m_status[i] = S_RDY;
        m_saved[1] = 512; m_saved[2] = 1024; m_saved[3] = 1536;
        m_cur = 1; m_cause = 0; m_hint = 1;
        m_sw = 0; m_wt = 0;
        e_valid = 0; e_pc = 0; e_mux = 1; e_halt = 0;
    endtask

    function automatic int choose();
        if (m_cause == 1 && m_status[m_hint] == S_RDY) return m_hint;
        for (int k = 1; k <= 3; k++) begin
            int p;
            p = (m_cur + k - 1) % 3 + 1;
            if (m_status[p] == S_RDY) return p;
        end
        return 0;
    endfunction

    task automatic model_step();
        int  pick;
        bit  transit;
        bit  waiting;
        pick    = choose();
        waiting = 0;
        for (int i = 1; i <= 3; i++) if (m_status[i] == S_WAIT) waiting = 1;
        transit = e_valid;
        e_valid = 0;
        for (int i = 1; i <= 3; i++)
            if (io_done[i-1] && m_status[i] == S_WAIT) m_status[i] = S_RDY;
        case (m_mode)
            M_RUN: if (!transit && jump_enabler && state_register >= 1 && state_register <= 5) begin
                m_saved[m_cur] = program_counter;
                if (state_register <= 3) begin m_cause = 1; m_hint = state_register; end
                else if (state_register == 4) begin m_cause = 4; m_status[m_cur] = S_WAIT; end
                else begin m_cause = 5; m_status[m_cur] = S_HALT; end
                e_valid = 1; e_pc = 256; e_mux = 0; m_mode = M_OS;
            end
            M_OS: if (!transit && opcode == SYSRET) m_mode = M_SEL;
            M_SEL: begin
                if (pick != 0) begin
                    e_valid = 1; e_pc = m_saved[pick]; m_cur = pick; e_mux = 1; m_mode = M_RUN;
                    if (m_sw < 65535) m_sw++;
                end else begin
                    if (m_wt < 65535) m_wt++;
                    if (!waiting) begin m_mode = M_STOP; e_halt = 1; end
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (chk_en) begin
                check("valid",  pc_override_valid,      e_valid);
                check("pc_ov",  pc_override,            e_pc);
                check("mux",    mux_system_instruction, e_mux);
                check("cur",    current_process,        m_cur);
                check("cause",  cause,                  m_cause);
                check("halted", all_halted,             e_halt);
`ifdef DISPATCH_STATS_EN
                check("switch_count", switch_count,   m_sw);
                check("io_wait",      io_wait_cycles, m_wt);
`endif
            end
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic idle();
        jump_enabler = 0; state_register = 0; opcode = 0; io_done = 0;
    endtask

    task automatic do_reset();
        reset_n = 0; idle(); step(); step(); reset_n = 1;
    endtask

    task automatic preempt(input int code, input int pc);
        jump_enabler = 1; state_register = code; program_counter = pc;
        step(); idle();
        check("enter_valid", pc_override_valid, 1);
        check("enter_pc",    pc_override, 256);
        check("enter_mux",   mux_system_instruction, 0);
    endtask

    task automatic sysret();
        step(); opcode = SYSRET; step(); opcode = 0;
    endtask

    task automatic expect_restore(input int pc, input int proc);
        step();
        check("restore_valid", pc_override_valid, 1);
        check("restore_pc",    pc_override, pc);
        check("restore_proc",  current_process, proc);
        check("restore_mux",   mux_system_instruction, 1);
        step();
        check("no_double_pulse", pc_override_valid, 0);
    endtask

    initial begin
        reset_n = 0; idle(); program_counter = 0;
        do_reset();
        chk_en = 1;
        check("rst_valid", pc_override_valid, 0);
        check("rst_pc",    pc_override, 0);
        check("rst_mux",   mux_system_instruction, 1);
        check("rst_cur",   current_process, 1);
        check("rst_cause", cause, 0);
        check("rst_halt",  all_halted, 0);

        // Timer switch to 2, then timer back to 1 exposes saved_pc[1] = 600.
        preempt(2, 600);
        check("timer_cause", cause, 1);
        sysret(); expect_restore(1024, 2);
        preempt(1, 1100); sysret(); expect_restore(600, 1);

        // Invalid codes are ignored in USER.
        jump_enabler = 1; state_register = 7; program_counter = 700; step();
        check("inv7_valid", pc_override_valid, 0);
        state_register = 32'h0000_0102; step(); idle();
        check("invwide_valid", pc_override_valid, 0);
        check("inv_mux", mux_system_instruction, 1);

        // Halt 2 and 3, then wait on 1 and release it via io_done.
        preempt(2, 610); sysret(); expect_restore(1100, 2);
        preempt(5, 1111);
        check("halt_cause", cause, 5);
        sysret(); expect_restore(1536, 3);
        preempt(5, 1600); sysret(); expect_restore(610, 1);
        preempt(4, 620);
        step();
        jump_enabler = 1; state_register = 2; program_counter = 999; step(); idle();
        opcode = SYSRET; step(); opcode = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sel_wait_valid", pc_override_valid, 0);
        end
        io_done = 3'b001; step(); io_done = 0;
        check("sel_io_valid", pc_override_valid, 0);
        expect_restore(620, 1);

        // Round robin from 3 skips halted 1 and lands on 2.
        do_reset();
        preempt(5, 700);  sysret(); expect_restore(1024, 2);
        preempt(3, 1050); sysret(); expect_restore(1536, 3);
        preempt(4, 1540); sysret(); expect_restore(1050, 2);

        // Release 3, halt 2 then 3 -> STOP.
        io_done = 3'b100; step(); idle();
        preempt(5, 1060); sysret(); expect_restore(1540, 3);
        preempt(5, 1570); sysret(); step();
        check("stop_halted", all_halted, 1);
        check("stop_mux", mux_system_instruction, 0);
        jump_enabler = 1; state_register = 2; opcode = SYSRET; io_done = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stop_valid", pc_override_valid, 0);
        end
        idle();

        // Asynchronous reset inside the ENTER cycle.
        do_reset();
        preempt(2, 900);
        #2 reset_n = 0;
        #1;
        check("rstmid_valid", pc_override_valid, 0);
        check("rstmid_pc",    pc_override, 0);
        check("rstmid_mux",   mux_system_instruction, 1);
        step(); reset_n = 1;

        // Randomized epochs against the model.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                jump_enabler    = ($urandom % 4) == 0;
                state_register  = (($urandom % 8) == 0) ? $urandom : ($urandom % 8);
                program_counter = 12'($urandom % 4096);
                opcode          = (($urandom % 3) == 0) ? SYSRET : 6'($urandom % 64);
                io_done         = (($urandom % 6) == 0) ? 3'($urandom % 8) : 3'b000;
                if (($urandom % 150) == 0) begin
                    #2 reset_n = 0;
                    #1 reset_n = 1;
                end
                step();
            end
        end
        idle();
        step();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tucanos_dispatcher.md
Name: tucanos_dispatcher

Overview:
- OS-side consumer of the watchdog's preemption interface (jump_enabler, state_register).
- On each preemption request it does three things:
  - saves the interrupted process PC;
  - records why the process was preempted;
  - forces the fetch unit to the OS entry address.
- When the OS executes SYSRET, it picks the next runnable process from a 3-entry process table and redirects fetch to that process's saved PC.
- It sits between the watchdog and the PC/fetch mux and drives the user/system select.

Parameters:
- OS_ENTRY_ADDR, 12'd256, PC forced on entry to the OS.
- PROC1_BASE, 12'd512, initial saved PC of process 1.
- PROC2_BASE, 12'd1024, initial saved PC of process 2.
- PROC3_BASE, 12'd1536, initial saved PC of process 3.
- SYSRET_OP, 6'b100100, opcode that returns control from the OS to user code.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- jump_enabler  in  1  preemption request from the watchdog.
- state_register  in  32  preemption code: 1..3 = timer switch to that index, 4 = wait (I/O), 5 = halt.
- program_counter  in  12  PC of the instruction being interrupted.
- opcode  in  6  currently executing opcode.
- io_done  in  3  one-hot I/O completion; bit i-1 belongs to process i.
- pc_override_valid  out  1  one-cycle pulse; fetch loads pc_override.
- pc_override  out  12  redirect target.
- mux_system_instruction  out  1  0 = BIOS/OS code, 1 = user process.
- current_process  out  2  running process index, 1..3.
- cause  out  3  last preemption code: 1 = timer, 4 = wait, 5 = halt, 0 = none.
- all_halted  out  1  high when every process is HALTED.

Behaviour:
- Reset values (asynchronous):
  - FSM state USER, current_process = 1, cause = 0.
  - pc_override_valid = 0, pc_override = 0, mux_system_instruction = 1, all_halted = 0.
  - saved_pc[i] = PROCi_BASE; status[i] = READY for all i.
- Process status encoding per entry: READY, WAITING, HALTED.
- FSM states: USER, ENTER, OS, SELECT, RESTORE, STOP.
- USER:
  - If jump_enabler = 1 at posedge, latch the code from state_register:
    - code 1..3: cause = 1, hint = code;
    - code 4: cause = 4, status[current] = WAITING;
    - code 5: cause = 5, status[current] = HALTED;
    - any other code: ignored, remain in USER.
  - For a valid code, saved_pc[current] = program_counter and go to ENTER.
- ENTER (one cycle): pc_override_valid = 1, pc_override = OS_ENTRY_ADDR, mux_system_instruction = 0; go to OS.
- OS:
  - jump_enabler is ignored.
  - When opcode == SYSRET_OP, go to SELECT.
- SELECT (one cycle, combinational pick registered), first match wins:
  - cause = 1 and status[hint] = READY -> next = hint;
  - otherwise, round robin from current+1, wrapping 3 -> 1, first READY entry; current itself is checked last.
  - If a READY entry is found, go to RESTORE.
  - If no READY entry but any WAITING, remain in SELECT, re-evaluating every cycle.
  - If all entries are HALTED, go to STOP.
- RESTORE (one cycle):
  - pc_override_valid = 1, pc_override = saved_pc[next];
  - current_process = next, mux_system_instruction = 1;
  - go to USER.
- STOP: all_halted = 1, mux_system_instruction = 0, no override; exited only by reset.
- io_done[i-1] = 1 in any state sets status[i] from WAITING to READY; it has no effect on READY or HALTED entries.
- Simultaneous events:
  - io_done and a wait code for the same process in the same cycle: the wait code wins, and the entry stays WAITING.
  - io_done during SELECT is visible to the selection in the next cycle.
- pc_override_valid is never high for two consecutive cycles.
- Redirect latency: 1 cycle after the jump_enabler sample; 2 cycles after SYSRET when a READY entry exists.
- Reset asserted mid-sequence aborts any pending override immediately.

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- Defined:
  - adds output switch_count[15:0], which increments on every RESTORE and saturates at 16'hFFFF;
  - adds output io_wait_cycles[15:0], which counts cycles spent in SELECT with no READY entry and saturates.
  - Both reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Timer switch: after reset, PC = 12'd600, jump_enabler = 1, state_register = 2 -> next cycle pc_override_valid = 1 with pc_override = 256; saved_pc[1] = 600; after SYSRET, pc_override = 1024 and current_process = 2.
- Wait then I/O: process 1 gets code 4, processes 2 and 3 are HALTED, then SYSRET -> dispatcher remains in SELECT; pulse io_done = 3'b001 -> the cycle after re-evaluation, pc_override equals saved_pc[1].
- Round robin skip: current = 3, code 4 with status[1] = HALTED and status[2] = READY -> pick wraps to process 2.
- All halted: code 5 delivered to processes 1, 2 and 3 in sequence, each followed by SYSRET -> all_halted = 1 and no further pc_override_valid.
- Invalid code / OS ignore: state_register = 7 in USER -> no transition; jump_enabler = 1 while in OS -> saved_pc is unchanged.
- Reset mid-ENTER: reset_n low in the ENTER cycle -> pc_override_valid = 0 immediately and saved_pc[1] = 512 on release.
